// File: rtl/tick_sequencer.sv
// Global tick sequencer for a neuron grid: broadcasts a tick, waits for every
// core to report done, repeats for the requested run length, and traps errors/timeouts.
module tick_sequencer #(
    parameter int NUM_CORES = 4,
    parameter int TICK_W    = 16,
    parameter int TMO_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 clear,
    input  logic [TICK_W-1:0]    num_ticks,
    input  logic [TMO_W-1:0]     timeout_cycles,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic [NUM_CORES-1:0] core_error,
    output logic                 tick,
    output logic                 busy,
    output logic [TICK_W-1:0]    tick_count,
    output logic                 run_done,
    output logic                 fault,
    output logic [NUM_CORES-1:0] fault_core
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TICK  = 2'd1,
        S_WAIT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [TICK_W-1:0]     tick_count_q, tick_count_d;
    logic [TICK_W-1:0]     num_ticks_q, num_ticks_d;
    logic [TMO_W-1:0]      timeout_q, timeout_d;
    logic [TMO_W-1:0]      wdog_q, wdog_d;
    logic [NUM_CORES-1:0]  done_mask_q, done_mask_d;
    logic [NUM_CORES-1:0]  fault_core_q, fault_core_d;
    logic                  run_done_q, run_done_d;

    logic [NUM_CORES-1:0]  pending;
    logic [TICK_W-1:0]     count_inc;
    logic [TMO_W-1:0]      wdog_inc;
    logic                  all_done;
    logic                  any_error;
    logic                  wdog_expired;

    // A core is still pending if it has neither reported earlier nor reports now.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_pending
            assign pending[gi] = ~(done_mask_q[gi] | core_done[gi]);
        end
    endgenerate

    assign all_done     = ~|pending;
    assign any_error    = |core_error;
    assign count_inc    = tick_count_q + TICK_W'(1);
    assign wdog_inc     = wdog_q + TMO_W'(1);
    assign wdog_expired = (timeout_q != '0) && (wdog_inc == timeout_q);

    always_comb begin
        state_d      = state_q;
        tick_count_d = tick_count_q;
        num_ticks_d  = num_ticks_q;
        timeout_d    = timeout_q;
        wdog_d       = wdog_q;
        done_mask_d  = done_mask_q;
        fault_core_d = fault_core_q;
        run_done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_ticks_d  = num_ticks;
                    timeout_d    = timeout_cycles;
                    tick_count_d = '0;
                    if (num_ticks == '0) begin
                        run_done_d = 1'b1;
                    end else begin
                        state_d = S_TICK;
                    end
                end
            end
            S_TICK: begin
                done_mask_d = '0;
                wdog_d      = '0;
                if (any_error) begin
                    state_d      = S_FAULT;
                    fault_core_d = core_error;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wdog_d      = wdog_inc;
                done_mask_d = done_mask_q | core_done;
                // Error beats watchdog, and both beat a completion landing in the same cycle.
                if (any_error) begin
                    state_d      = S_FAULT;
                    fault_core_d = core_error;
                end else if (wdog_expired) begin
                    state_d      = S_FAULT;
                    fault_core_d = pending;
                end else if (all_done) begin
                    tick_count_d = count_inc;
                    if (count_inc == num_ticks_q) begin
                        state_d    = S_IDLE;
                        run_done_d = 1'b1;
                    end else begin
                        state_d = S_TICK;
                    end
                end
            end
            S_FAULT: begin
                if (clear) begin
                    state_d      = S_IDLE;
                    fault_core_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            tick_count_q <= '0;
            num_ticks_q  <= '0;
            timeout_q    <= '0;
            wdog_q       <= '0;
            done_mask_q  <= '0;
            fault_core_q <= '0;
            run_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_count_q <= tick_count_d;
            num_ticks_q  <= num_ticks_d;
            timeout_q    <= timeout_d;
            wdog_q       <= wdog_d;
            done_mask_q  <= done_mask_d;
            fault_core_q <= fault_core_d;
            run_done_q   <= run_done_d;
        end
    end

    assign tick       = (state_q == S_TICK);
    assign busy       = (state_q == S_TICK) || (state_q == S_WAIT);
    assign fault      = (state_q == S_FAULT);
    assign tick_count = tick_count_q;
    assign run_done   = run_done_q;
    assign fault_core = fault_core_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Bench for tick_sequencer: each run is planned as a timeline of tick/complete/fault
// slots from per-core done delays, then replayed and compared slot by slot.
module tb_tick_sequencer;

    localparam int NC    = 4;
    localparam int TW    = 16;
    localparam int MW    = 16;
    localparam int H     = 96;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          clear;
    logic [TW-1:0] num_ticks;
    logic [MW-1:0] timeout_cycles;
    logic [NC-1:0] core_done;
    logic [NC-1:0] core_error;
    logic          tick;
    logic          busy;
    logic [TW-1:0] tick_count;
    logic          run_done;
    logic          fault;
    logic [NC-1:0] fault_core;

    always #5 clk = ~clk;

    tick_sequencer #(.NUM_CORES(NC), .TICK_W(TW), .TMO_W(MW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .clear          (clear),
        .num_ticks      (num_ticks),
        .timeout_cycles (timeout_cycles),
        .core_done      (core_done),
        .core_error     (core_error),
        .tick           (tick),
        .busy           (busy),
        .tick_count     (tick_count),
        .run_done       (run_done),
        .fault          (fault),
        .fault_core     (fault_core)
    );

    int total = 0;
    int bad   = 0;

    // dly[k][i]: cycles after tick k's broadcast at which core i reports done
    int            dly [0:7][0:NC-1];
    logic          drv_start [H];
    logic          drv_clear [H];
    logic          drv_rstn  [H];
    logic [NC-1:0] drv_done  [H];
    logic [NC-1:0] drv_err   [H];
    // {tick, busy, run_done, fault, tick_count[15:0], fault_core[3:0]}
    logic [23:0]   exp_vec   [H];
    logic [23:0]   obs_vec   [H];

    function automatic logic [23:0] pack(input logic tk, input logic bs, input logic rd,
                                         input logic ft, input int cnt, input logic [NC-1:0] fc);
        return {tk, bs, rd, ft, TW'(cnt), fc};
    endfunction

    task automatic fill_dly(input int d0, input int d1, input int d2, input int d3);
        for (int k = 0; k < 8; k++) begin
            dly[k][0] = d0; dly[k][1] = d1; dly[k][2] = d2; dly[k][3] = d3;
        end
    endtask

    // Slot j: inputs sampled at edge j, outputs observed after edge j.
    // A core reporting during cycle j is driven in slot j+1.
    task automatic build_run(input int n, input int tmo, input int err_k, input int err_off,
                             input logic [NC-1:0] err_mask, input int clr_after, input int rst_slot);
        int t, cnt, dmax, wend, kind, fend;
        logic [NC-1:0] fc;
        logic [23:0] tail;
        for (int j = 0; j < H; j++) begin
            drv_start[j] = 1'b0; drv_clear[j] = 1'b0; drv_rstn[j] = 1'b1;
            drv_done[j] = '0; drv_err[j] = '0; exp_vec[j] = '0;
        end
        drv_start[0] = 1'b1;
        t = 0; cnt = 0; fend = 0; tail = '0;
        if (n == 0) begin
            exp_vec[0] = pack(1'b0, 1'b0, 1'b1, 1'b0, 0, '0);
            fend = 1;
        end else begin
            for (int k = 0; k < n; k++) begin
                dmax = 0;
                for (int i = 0; i < NC; i++) if (dly[k][i] > dmax) dmax = dly[k][i];
                kind = 0; fc = '0; wend = t + dmax;
                if (tmo != 0 && dmax >= tmo) begin
                    kind = 1; wend = t + tmo;
                    for (int i = 0; i < NC; i++) fc[i] = (dly[k][i] > tmo);
                end
                if (err_k == k && err_off <= wend - t) begin
                    kind = 2; wend = t + err_off; fc = err_mask;
                    drv_err[wend + 1] = err_mask;
                end
                for (int j = t; j <= wend; j++) exp_vec[j] = pack(j == t, 1'b1, 1'b0, 1'b0, cnt, '0);
                for (int i = 0; i < NC; i++)
                    if (dly[k][i] <= wend - t) drv_done[t + dly[k][i] + 1][i] = 1'b1;
                if (kind != 0) begin
                    for (int j = wend + 1; j < wend + 1 + clr_after; j++)
                        exp_vec[j] = pack(1'b0, 1'b0, 1'b0, 1'b1, cnt, fc);
                    drv_clear[wend + 1 + clr_after] = 1'b1;
                    fend = wend + 1 + clr_after;
                    tail = pack(1'b0, 1'b0, 1'b0, 1'b0, cnt, '0);
                    break;
                end
                cnt++;
                t = wend + 1;
                if (cnt == n) begin
                    exp_vec[t] = pack(1'b0, 1'b0, 1'b1, 1'b0, cnt, '0);
                    fend = t + 1;
                    tail = pack(1'b0, 1'b0, 1'b0, 1'b0, cnt, '0);
                end
            end
        end
        for (int j = fend; j < H; j++) exp_vec[j] = tail;
        if (rst_slot >= 0) begin
            drv_rstn[rst_slot] = 1'b0;
            for (int j = rst_slot; j < H; j++) begin
                exp_vec[j] = '0; drv_done[j] = '0; drv_err[j] = '0; drv_clear[j] = 1'b0;
            end
        end
    endtask

    // num_ticks/timeout_cycles only meaningful at slot 0; scrambled elsewhere.
    task automatic play(input int n, input int tmo);
        for (int j = 0; j < H; j++) begin
            reset_n        = drv_rstn[j];
            start          = drv_start[j];
            clear          = drv_clear[j];
            core_done      = drv_done[j];
            core_error     = drv_err[j];
            num_ticks      = (j == 0) ? TW'(n)   : TW'($urandom_range(0, 7));
            timeout_cycles = (j == 0) ? MW'(tmo) : MW'($urandom_range(0, 9));
            @(posedge clk);
            @(negedge clk);
            obs_vec[j] = {tick, busy, run_done, fault, tick_count, fault_core};
        end
        reset_n = 1'b1; start = 1'b0; clear = 1'b0; core_done = '0; core_error = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1; clear = 1'b1; num_ticks = 16'd5; timeout_cycles = 16'd3;
        core_done = '1; core_error = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (tick !== 1'b0)       begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (run_done !== 1'b0)   begin bad++; $display("FAIL reset_run_done got=%b exp=0", run_done); end
        total++; if (fault !== 1'b0)      begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
        total++; if (tick_count !== '0)   begin bad++; $display("FAIL reset_tick_count got=%0d exp=0", tick_count); end
        total++; if (fault_core !== '0)   begin bad++; $display("FAIL reset_fault_core got=%b exp=0", fault_core); end
        reset_n = 1'b1; start = 1'b0; clear = 1'b0; core_done = '0; core_error = '0;
        @(posedge clk); @(negedge clk);
        $display("test_reset: done");
    endtask

    task automatic test_basic_run();
        int nt, nd;
        fill_dly(2, 2, 2, 2);
        build_run(3, 0, -1, 0, '0, 1, -1);
        play(3, 0);
        nt = 0; nd = 0;
        for (int j = 0; j < H; j++) begin
            nt += int'(obs_vec[j][23]); nd += int'(obs_vec[j][21]);
            total++;
            if (obs_vec[j] !== exp_vec[j]) begin bad++; $display("FAIL basic slot=%0d got=%h exp=%h", j, obs_vec[j], exp_vec[j]); end
        end
        total++; if (nt !== 3) begin bad++; $display("FAIL basic_tick_pulses got=%0d exp=3", nt); end
        total++; if (nd !== 1) begin bad++; $display("FAIL basic_run_done_pulses got=%0d exp=1", nd); end
        total++; if (obs_vec[H-1][19:4] !== 16'd3) begin bad++; $display("FAIL basic_final_count got=%0d exp=3", obs_vec[H-1][19:4]); end
        $display("test_basic_run: ticks=%0d run_done=%0d", nt, nd);
    endtask

    task automatic test_staggered();
        fill_dly(1, 2, 3, 5);
        build_run(1, 0, -1, 0, '0, 1, -1);
        play(1, 0);
        for (int j = 0; j < H; j++) begin
            total++;
            if (obs_vec[j] !== exp_vec[j]) begin bad++; $display("FAIL stagger slot=%0d got=%h exp=%h", j, obs_vec[j], exp_vec[j]); end
        end
        total++; if (obs_vec[6][21] !== 1'b1) begin bad++; $display("FAIL stagger_run_done_slot6 got=%b exp=1", obs_vec[6][21]); end
        total++; if (obs_vec[5][22] !== 1'b1) begin bad++; $display("FAIL stagger_busy_slot5 got=%b exp=1", obs_vec[5][22]); end
        $display("test_staggered: run_done at slot 6 expected");
    endtask

    task automatic test_timeout();
        fill_dly(2, 2, NEVER, 2);
        build_run(2, 8, -1, 0, '0, 3, -1);
        play(2, 8);
        for (int j = 0; j < H; j++) begin
            total++;
            if (obs_vec[j] !== exp_vec[j]) begin bad++; $display("FAIL timeout slot=%0d got=%h exp=%h", j, obs_vec[j], exp_vec[j]); end
        end
        total++; if (obs_vec[8][20] !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b exp=0", obs_vec[8][20]); end
        total++; if (obs_vec[9][3:0] !== 4'b0100) begin bad++; $display("FAIL timeout_fault_core got=%b exp=0100", obs_vec[9][3:0]); end
        // completion one cycle before the limit, then completion on the limit itself
        fill_dly(4, 4, 4, 4);
        build_run(1, 5, -1, 0, '0, 1, -1);
        play(1, 5);
        for (int j = 0; j < H; j++) begin
            total++;
            if (obs_vec[j] !== exp_vec[j]) begin bad++; $display("FAIL timeout_margin slot=%0d got=%h exp=%h", j, obs_vec[j], exp_vec[j]); end
        end
        build_run(1, 4, -1, 0, '0, 2, -1);
        play(1, 4);
        for (int j = 0; j < H; j++) begin
            total++;
            if (obs_vec[j] !== exp_vec[j]) begin bad++; $display("FAIL timeout_edge slot=%0d got=%h exp=%h", j, obs_vec[j], exp_vec[j]); end
        end
        $display("test_timeout: three runs");
    endtask

    task automatic test_error_final();
        int nd;
        fill_dly(2, 2, 2, 4);
        build_run(2, 0, 0, 4, 4'b0010, 2, -1);
        play(2, 0);
        nd = 0;
        for (int j = 0; j < H; j++) begin
            nd += int'(obs_vec[j][21]);
            total++;
            if (obs_vec[j] !== exp_vec[j]) begin bad++; $display("FAIL errfinal slot=%0d got=%h exp=%h", j, obs_vec[j], exp_vec[j]); end
        end
        total++; if (nd !== 0) begin bad++; $display("FAIL errfinal_run_done got=%0d exp=0", nd); end
        total++; if (obs_vec[5][3:0] !== 4'b0010) begin bad++; $display("FAIL errfinal_fault_core got=%b exp=0010", obs_vec[5][3:0]); end
        $display("test_error_final: fault_core=%b", obs_vec[5][3:0]);
    endtask

    task automatic test_zero_and_busy_start();
        build_run(0, 0, -1, 0, '0, 1, -1);
        play(0, 0);
        for (int j = 0; j < H; j++) begin
            total++;
            if (obs_vec[j] !== exp_vec[j]) begin bad++; $display("FAIL zero slot=%0d got=%h exp=%h", j, obs_vec[j], exp_vec[j]); end
        end
        fill_dly(3, 1, 2, 3);
        build_run(2, 0, -1, 0, '0, 1, -1);
        drv_start[2] = 1'b1;
        drv_start[5] = 1'b1;
        play(2, 0);
        for (int j = 0; j < H; j++) begin
            total++;
            if (obs_vec[j] !== exp_vec[j]) begin bad++; $display("FAIL busystart slot=%0d got=%h exp=%h", j, obs_vec[j], exp_vec[j]); end
        end
        $display("test_zero_and_busy_start: two runs");
    endtask

    task automatic test_reset_mid_run();
        int nt;
        fill_dly(3, 3, 3, 3);
        build_run(3, 0, -1, 0, '0, 1, 6);
        play(3, 0);
        nt = 0;
        for (int j = 0; j < H; j++) begin
            if (j >= 6) nt += int'(obs_vec[j][23]);
            total++;
            if (obs_vec[j] !== exp_vec[j]) begin bad++; $display("FAIL midreset slot=%0d got=%h exp=%h", j, obs_vec[j], exp_vec[j]); end
        end
        total++; if (nt !== 0) begin bad++; $display("FAIL midreset_ticks_after got=%0d exp=0", nt); end
        $display("test_reset_mid_run: ticks after reset=%0d", nt);
    endtask

    task automatic test_random();
        int n, tmo, ek, eo, s, errs;
        logic [NC-1:0] em;
        for (int r = 0; r < 25; r++) begin
            n   = int'($urandom_range(0, 4));
            tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(3, 9));
            for (int k = 0; k < 8; k++)
                for (int i = 0; i < NC; i++) begin
                    dly[k][i] = int'($urandom_range(1, 8));
                    if (tmo != 0 && $urandom_range(0, 9) == 0) dly[k][i] = NEVER;
                end
            ek = -1; eo = 0; em = '0;
            if ($urandom_range(0, 3) == 0) begin
                ek = int'($urandom_range(0, 3));
                eo = int'($urandom_range(0, 8));
                em = NC'($urandom_range(1, 15));
            end
            build_run(n, tmo, ek, eo, em, int'($urandom_range(1, 3)), -1);
            s = int'($urandom_range(1, 20));
            if (exp_vec[s-1][22]) drv_start[s] = 1'b1;
            play(n, tmo);
            errs = 0;
            for (int j = 0; j < H; j++) begin
                total++;
                if (obs_vec[j] !== exp_vec[j]) begin
                    bad++; errs++;
                    $display("FAIL random run=%0d slot=%0d got=%h exp=%h", r, j, obs_vec[j], exp_vec[j]);
                end
            end
            $display("test_random: run=%0d n=%0d tmo=%0d err_tick=%0d slot_errors=%0d", r, n, tmo, ek, errs);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; clear = 1'b0; num_ticks = '0; timeout_cycles = '0;
        core_done = '0; core_error = '0;
        test_reset();
        test_basic_run();
        test_staggered();
        test_timeout();
        test_error_final();
        test_zero_and_busy_start();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tick_sequencer.md
TICK_SEQUENCER -- requirements
Module: tick_sequencer

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, meaning number of neuron grid cores sequenced.
REQ-002 SHALL have parameter TICK_W, default 16, meaning width of tick count and run length.
REQ-003 SHALL have parameter TMO_W, default 16, meaning width of the per-tick watchdog.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, meaning synchronous active-low reset.
REQ-006 SHALL have port start, input, 1, meaning run request, sampled only in IDLE.
REQ-007 SHALL have port clear, input, 1, meaning fault clear, effective only in FAULT.
REQ-008 SHALL have port num_ticks, input, TICK_W, meaning ticks per run, latched on accepted start.
REQ-009 SHALL have port timeout_cycles, input, TMO_W, meaning watchdog limit, latched on accepted start; 0 disables it.
REQ-010 SHALL have port core_done, input, NUM_CORES, meaning per-core one-cycle done pulse.
REQ-011 SHALL have port core_error, input, NUM_CORES, meaning per-core error level.
REQ-012 SHALL have port tick, output, 1, meaning one-cycle tick broadcast to all cores.
REQ-013 SHALL have port busy, output, 1, meaning state is TICK or WAIT.
REQ-014 SHALL have port tick_count, output, TICK_W, meaning ticks completed in the current/last run.
REQ-015 SHALL have port run_done, output, 1, meaning one-cycle pulse at run completion.
REQ-016 SHALL have port fault, output, 1, meaning state is FAULT.
REQ-017 SHALL have port fault_core, output, NUM_CORES, meaning cores implicated in the fault.

Function
REQ-018 SHALL implement states IDLE, TICK, WAIT, FAULT; all outputs registered/Moore.
REQ-019 SHALL, in IDLE with start=1, latch num_ticks/timeout_cycles, clear tick_count, and go to TICK; if num_ticks=0, stay IDLE and pulse run_done next cycle with no tick.
REQ-020 SHALL ignore start outside IDLE.
REQ-021 SHALL assert tick exactly in TICK (one cycle), clear done_mask and watchdog, then go to WAIT.
REQ-022 SHALL, in WAIT, set done_mask bits from core_done (sticky); core_done in other states ignored.
REQ-023 SHALL treat a tick complete in the cycle where (done_mask | core_done) is all ones; next cycle tick_count +1.
REQ-024 SHALL, on completion with tick_count+1 = latched num_ticks, go to IDLE and pulse run_done; else go to TICK (minimum tick period 2 cycles after last done).
REQ-025 SHALL increment the watchdog each WAIT cycle; when it reaches a nonzero latched timeout_cycles without completion, go to FAULT with fault_core = ~(done_mask | core_done).
REQ-026 SHALL, on any core_error bit in TICK or WAIT, go to FAULT with fault_core = core_error.
REQ-027 SHALL give error priority over timeout, and both over completion in the same cycle.
REQ-028 SHALL hold tick_count and fault_core in FAULT; clear=1 returns to IDLE and clears fault_core.
REQ-029 SHALL not wrap tick_count: it never exceeds latched num_ticks.
REQ-030 SHALL keep tick_count stable in IDLE after a run, until the next accepted start.

Reset
REQ-031 SHALL, with reset_n=0 at a clock edge, enter IDLE and drive tick=0, busy=0, run_done=0, fault=0, tick_count=0, fault_core=0, clearing done_mask, watchdog and latched values.
REQ-032 SHALL apply reset mid-run (any state) with identical result, emitting no further tick.

Verification
REQ-033 SHALL cover: NUM_CORES=4, num_ticks=3, all cores done 2 cycles after each tick -> 3 tick pulses, tick_count 1,2,3, single run_done, busy low after.
REQ-034 SHALL cover: done pulses staggered (core0 cycle1, core3 cycle5) -> completion only after core3, no early tick.
REQ-035 SHALL cover: timeout_cycles=8, core2 never done -> fault=1 after 8 WAIT cycles, fault_core=4'b0100; clear -> IDLE.
REQ-036 SHALL cover: core_error=4'b0010 in same cycle final done arrives -> FAULT, fault_core=4'b0010, no run_done.
REQ-037 SHALL cover: num_ticks=0 -> run_done next cycle, no tick; start while busy -> ignored.
REQ-038 SHALL cover: reset_n=0 during WAIT of tick 2 -> all outputs 0 next cycle, no tick until new start.
